// File: rtl/chs_pkg.sv
// chs_pkg: shared definitions for the multi-zone cool/heat controller.
//   chs_state_e : per-zone FSM state encoding
//   LVL_MAX     : top power level (0..LVL_MAX)
//   LVL_W       : power level width
package chs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HEAT  = 2'd1,
    ST_COOL  = 2'd2,
    ST_DRAIN = 2'd3
  } chs_state_e;

  localparam int LVL_MAX = 15;
  localparam int LVL_W   = 4;

endpackage

// File: rtl/chs_zone.sv
// chs_zone: one HVAC zone -- heat/cool/drain FSM with hysteresis, target
// level computation and slew-limited power register.
//   clk      : system clock
//   i_rst_n  : synchronous active-low reset
//   i_tick   : shared ramp tick (one cycle wide)
//   i_en     : zone enable
//   i_meas   : measured temperature
//   i_set    : setpoint temperature
//   o_power  : current power level 0..LVL_MAX
//   o_mode   : 1 = heat, 0 = cool (changes only on IDLE exit)
//   o_active : 1 when state is not IDLE
module chs_zone
  import chs_pkg::*;
#(
  parameter int TEMP_W = 8,
  parameter int HYST   = 2
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  input  logic              i_en,
  input  logic [TEMP_W-1:0] i_meas,
  input  logic [TEMP_W-1:0] i_set,
  output logic [LVL_W-1:0]  o_power,
  output logic              o_mode,
  output logic              o_active
);

  localparam logic signed [TEMP_W:0] P_HYST  = (TEMP_W+1)'(HYST);
  localparam logic signed [TEMP_W:0] P_NHYST = -P_HYST;
  localparam logic [TEMP_W:0]        P_LMAX  = (TEMP_W+1)'(LVL_MAX);

  chs_state_e        r_state;
  logic [LVL_W-1:0]  r_power;
  logic              r_mode;
  logic              r_active;

  // set - meas in one extra bit so set +/- HYST comparisons never wrap
  logic signed [TEMP_W:0] w_diff;
  logic        [TEMP_W:0] w_mag;
  logic                   w_heat_go;
  logic                   w_cool_go;
  logic                   w_heat_done;
  logic                   w_cool_done;
  logic [LVL_W-1:0]       w_target;

  assign w_diff      = $signed({1'b0, i_set}) - $signed({1'b0, i_meas});
  assign w_mag       = w_diff[TEMP_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_heat_go   = w_diff > P_HYST;               // meas < set - HYST
  assign w_cool_go   = w_diff < P_NHYST;              // meas > set + HYST
  assign w_heat_done = w_diff[TEMP_W] || (w_diff == '0);  // meas >= set
  assign w_cool_done = !w_diff[TEMP_W];                   // meas <= set

  // Target follows the current state, so a tick coinciding with a state
  // exit still ramps toward the old state's target.
  always_comb begin
    w_target = '0;
    if (r_state == ST_HEAT || r_state == ST_COOL) begin
      if (w_mag > P_LMAX) w_target = LVL_W'(LVL_MAX);
      else                w_target = w_mag[LVL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_power  <= '0;
      r_mode   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      if (i_tick) begin
        if (r_power < w_target)      r_power <= r_power + LVL_W'(1);
        else if (r_power > w_target) r_power <= r_power - LVL_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (i_en && w_heat_go) begin
            r_state  <= ST_HEAT;
            r_mode   <= 1'b1;
            r_active <= 1'b1;
          end else if (i_en && w_cool_go) begin
            r_state  <= ST_COOL;
            r_mode   <= 1'b0;
            r_active <= 1'b1;
          end
        end
        ST_HEAT: if (!i_en || w_heat_done) r_state <= ST_DRAIN;
        ST_COOL: if (!i_en || w_cool_done) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (r_power == '0) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_power  = r_power;
  assign o_mode   = r_mode;
  assign o_active = r_active;

endmodule

// File: rtl/multi_zone_chs.sv
// multi_zone_chs: NZONE independent cool/heat zones sharing one ramp
// prescaler and one PWM carrier.
//   clk        : system clock
//   arst_n     : synchronous active-low reset
//   zone_en    : per-zone enable
//   temp_meas  : measured temps, zone i at [i*TEMP_W +: TEMP_W]
//   temp_set   : setpoints, same packing
//   chs_power  : per-zone power level, zone i at [i*4 +: 4]
//   chs_mode   : per-zone 1 = heat, 0 = cool
//   chs_active : per-zone not-IDLE flag
//   pwm_data   : per-zone PWM drive (registered, one cycle behind cnt/power)
module multi_zone_chs
  import chs_pkg::*;
#(
  parameter int NZONE    = 4,
  parameter int TEMP_W   = 8,
  parameter int PWM_W    = 8,
  parameter int RAMP_CYC = 16,
  parameter int HYST     = 2
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [NZONE-1:0]        zone_en,
  input  logic [NZONE*TEMP_W-1:0] temp_meas,
  input  logic [NZONE*TEMP_W-1:0] temp_set,
  output logic [NZONE*LVL_W-1:0]  chs_power,
  output logic [NZONE-1:0]        chs_mode,
  output logic [NZONE-1:0]        chs_active,
  output logic [NZONE-1:0]        pwm_data
);

  localparam int PRE_W = (RAMP_CYC > 2) ? $clog2(RAMP_CYC) : 1;
  localparam logic [PRE_W-1:0] P_PRE_LAST = PRE_W'(RAMP_CYC - 1);

  logic [PRE_W-1:0] r_pre;
  logic [PWM_W-1:0] r_cnt;
  logic [NZONE-1:0] r_pwm;
  logic             w_tick;

  assign w_tick = (r_pre == P_PRE_LAST);

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      r_cnt <= r_cnt + PWM_W'(1);
    end
  end

  for (genvar gi = 0; gi < NZONE; gi++) begin : g_zone
    logic [LVL_W-1:0] w_power;
    logic [PWM_W-1:0] w_duty;

    chs_zone #(
      .TEMP_W (TEMP_W),
      .HYST   (HYST)
    ) u_zone (
      .clk      (clk),
      .i_rst_n  (arst_n),
      .i_tick   (w_tick),
      .i_en     (zone_en[gi]),
      .i_meas   (temp_meas[gi*TEMP_W +: TEMP_W]),
      .i_set    (temp_set[gi*TEMP_W +: TEMP_W]),
      .o_power  (w_power),
      .o_mode   (chs_mode[gi]),
      .o_active (chs_active[gi])
    );

    // power in the top 4 bits of the carrier: 15 -> 15/16 duty, 0 -> off
    assign w_duty = PWM_W'(w_power) << (PWM_W - LVL_W);

    always_ff @(posedge clk) begin
      if (!arst_n) r_pwm[gi] <= 1'b0;
      else         r_pwm[gi] <= (r_cnt < w_duty);
    end

    assign chs_power[gi*LVL_W +: LVL_W] = w_power;
  end

  assign pwm_data = r_pwm;

endmodule

// File: tb/tb_multi_zone_chs.sv
module tb_multi_zone_chs;

  localparam int NZONE    = 4;
  localparam int TEMP_W   = 8;
  localparam int PWM_W    = 8;
  localparam int RAMP_CYC = 16;
  localparam int HYST     = 2;

  logic                    clk;
  logic                    arst_n;
  logic [NZONE-1:0]        zone_en;
  logic [NZONE*TEMP_W-1:0] temp_meas;
  logic [NZONE*TEMP_W-1:0] temp_set;
  logic [NZONE*4-1:0]      chs_power;
  logic [NZONE-1:0]        chs_mode;
  logic [NZONE-1:0]        chs_active;
  logic [NZONE-1:0]        pwm_data;

  multi_zone_chs #(
    .NZONE(NZONE), .TEMP_W(TEMP_W), .PWM_W(PWM_W),
    .RAMP_CYC(RAMP_CYC), .HYST(HYST)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .zone_en    (zone_en),
    .temp_meas  (temp_meas),
    .temp_set   (temp_set),
    .chs_power  (chs_power),
    .chs_mode   (chs_mode),
    .chs_active (chs_active),
    .pwm_data   (pwm_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic       en;
    logic [7:0] meas;
    logic [7:0] set;
    logic       exp_act;
    logic       exp_mode;
  } vec_t;

  vec_t tv[16];

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // zone 0 driven, zones 1..3 enabled with meas == set (must stay idle)
  task automatic drive0(input logic en, input logic [7:0] meas, input logic [7:0] set);
    zone_en   = {3'b111, en};
    temp_meas = {8'd70, 8'd70, 8'd70, meas};
    temp_set  = {8'd70, 8'd70, 8'd70, set};
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    step(3);
    arst_n = 1'b1;
  endtask

  task automatic wait_power(input int lvl, input int budget, input string name);
    int i;
    i = 0;
    while (int'(chs_power[3:0]) != lvl && i < budget) begin
      step();
      i++;
    end
    chk(name, int'(chs_power[3:0]), lvl);
  endtask

  initial begin
    int cnt, cnt1, prev, bad, saw_idle, done;

    arst_n = 1'b1;
    drive0(1'b0, 8'd0, 8'd0);

    tv[0]  = '{1'b1, 8'd68,  8'd70,  1'b0, 1'b0};
    tv[1]  = '{1'b1, 8'd69,  8'd70,  1'b0, 1'b0};
    tv[2]  = '{1'b1, 8'd70,  8'd70,  1'b0, 1'b0};
    tv[3]  = '{1'b1, 8'd71,  8'd70,  1'b0, 1'b0};
    tv[4]  = '{1'b1, 8'd72,  8'd70,  1'b0, 1'b0};
    tv[5]  = '{1'b1, 8'd67,  8'd70,  1'b1, 1'b1};
    tv[6]  = '{1'b1, 8'd73,  8'd70,  1'b1, 1'b0};
    tv[7]  = '{1'b0, 8'd60,  8'd70,  1'b0, 1'b0};
    tv[8]  = '{1'b1, 8'd0,   8'd1,   1'b0, 1'b0};
    tv[9]  = '{1'b1, 8'd0,   8'd2,   1'b0, 1'b0};
    tv[10] = '{1'b1, 8'd0,   8'd3,   1'b1, 1'b1};
    tv[11] = '{1'b1, 8'd255, 8'd254, 1'b0, 1'b0};
    tv[12] = '{1'b1, 8'd255, 8'd253, 1'b0, 1'b0};
    tv[13] = '{1'b1, 8'd255, 8'd252, 1'b1, 1'b0};
    tv[14] = '{1'b1, 8'd0,   8'd255, 1'b1, 1'b1};
    tv[15] = '{1'b1, 8'd255, 8'd0,   1'b1, 1'b0};

    // ---- reset with random inputs
    arst_n    = 1'b0;
    zone_en   = NZONE'($urandom);
    temp_meas = {$urandom, $urandom};
    temp_set  = {$urandom, $urandom};
    for (int r = 0; r < 3; r++) begin
      step();
      chk("rst_power",  int'(chs_power),  0);
      chk("rst_mode",   int'(chs_mode),   0);
      chk("rst_active", int'(chs_active), 0);
      chk("rst_pwm",    int'(pwm_data),   0);
    end
    arst_n = 1'b1;

    // ---- FSM entry / hysteresis vectors, each from a fresh reset
    for (int v = 0; v < 16; v++) begin
      drive0(tv[v].en, tv[v].meas, tv[v].set);
      do_reset();
      step();
      chk($sformatf("vec%0d_active", v), int'(chs_active[0]), int'(tv[v].exp_act));
      chk($sformatf("vec%0d_mode", v),   int'(chs_mode[0]),   int'(tv[v].exp_mode));
      chk($sformatf("vec%0d_power", v),  int'(chs_power[3:0]), 0);
      chk($sformatf("vec%0d_others", v), int'(chs_active[3:1]), 0);
    end

    // ---- heat ramp, exact tick timing (target 10)
    drive0(1'b1, 8'd60, 8'd70);
    do_reset();
    step();
    chk("heat_active", int'(chs_active[0]), 1);
    chk("heat_mode",   int'(chs_mode[0]),   1);
    step(14);
    chk("heat_p_before_tick", int'(chs_power[3:0]), 0);
    step();
    chk("heat_p_first_tick", int'(chs_power[3:0]), 1);
    step(143);
    chk("heat_p_159", int'(chs_power[3:0]), 9);
    step();
    chk("heat_p_160", int'(chs_power[3:0]), 10);
    prev = 10; bad = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (int'(chs_power[3:0]) != 10) bad++;
      if (chs_power[15:4] != '0 || chs_active[3:1] != '0) bad++;
    end
    chk("heat_hold_and_others", bad, 0);

    // ---- enter heat at 67, drain at 70 back to idle
    drive0(1'b1, 8'd67, 8'd70);
    do_reset();
    wait_power(3, 100, "hyst_reach3");
    drive0(1'b1, 8'd70, 8'd70);
    step();
    chk("hyst_drain_active", int'(chs_active[0]), 1);
    cnt = 0; bad = 0; prev = int'(chs_power[3:0]);
    while (chs_active[0] && cnt < 100) begin
      step();
      cnt++;
      if (int'(chs_power[3:0]) > prev) bad++;
      prev = int'(chs_power[3:0]);
    end
    chk("hyst_idle_reached", int'(chs_active[0]), 0);
    chk("hyst_idle_power",   int'(chs_power[3:0]), 0);
    chk("hyst_mode_held",    int'(chs_mode[0]), 1);
    chk("hyst_no_rise",      bad, 0);

    // ---- reversal heat(5) -> drain -> idle -> cool
    drive0(1'b1, 8'd65, 8'd70);
    do_reset();
    wait_power(5, 120, "rev_reach5");
    drive0(1'b1, 8'd90, 8'd70);
    cnt = 0; bad = 0; saw_idle = 0; done = 0; prev = 5;
    while (!done && cnt < 300) begin
      step();
      cnt++;
      if (int'(chs_power[3:0]) - prev > 1 || prev - int'(chs_power[3:0]) > 1) bad++;
      prev = int'(chs_power[3:0]);
      if (!chs_active[0]) begin
        saw_idle = 1;
        if (chs_power[3:0] != 4'd0) bad++;
      end
      if (!chs_mode[0] && !saw_idle) bad++;
      if (!chs_mode[0] && saw_idle && cnt > 0 && chs_active[0]) done = 1;
    end
    chk("rev_cool_reached", done, 1);
    chk("rev_saw_idle",     saw_idle, 1);
    chk("rev_no_violation", bad, 0);
    // drain from 5 needs 5 ticks: more than 4*RAMP_CYC cycles
    chk("rev_drain_slow", int'(cnt > 4*RAMP_CYC), 1);
    wait_power(15, 300, "rev_cool_power15");

    // ---- PWM duty for power 8 and 15, idle zone never high
    drive0(1'b1, 8'd62, 8'd70);
    do_reset();
    wait_power(8, 200, "pwm_reach8");
    step(2);
    cnt = 0; cnt1 = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      cnt  += int'(pwm_data[0]);
      cnt1 += int'(pwm_data[1]);
    end
    chk("pwm_duty8",  cnt, 128);
    chk("pwm_duty0",  cnt1, 0);
    drive0(1'b1, 8'd40, 8'd70);
    do_reset();
    wait_power(15, 300, "pwm_reach15");
    step(2);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      cnt += int'(pwm_data[0]);
    end
    chk("pwm_duty15", cnt, 240);

    // ---- zone_en dropped at power 12
    drive0(1'b1, 8'd58, 8'd70);
    do_reset();
    wait_power(12, 250, "en_reach12");
    drive0(1'b0, 8'd58, 8'd70);
    step();
    chk("en_drain_active", int'(chs_active[0]), 1);
    cnt = 0;
    while (chs_active[0] && cnt < 300) begin
      step();
      cnt++;
    end
    chk("en_idle_reached", int'(chs_active[0]), 0);
    chk("en_idle_power",   int'(chs_power[3:0]), 0);
    // a 12-level drain takes at least 11 full prescaler periods
    chk("en_drain_slow",   int'(cnt > 11*RAMP_CYC), 1);
    step(40);
    chk("en_stay_idle",    int'(chs_active[0]), 0);

    // ---- reset pulse at power 12
    drive0(1'b1, 8'd58, 8'd70);
    do_reset();
    wait_power(12, 250, "rst_reach12");
    arst_n = 1'b0;
    step();
    chk("rstp_power",  int'(chs_power[3:0]), 0);
    chk("rstp_active", int'(chs_active[0]), 0);
    chk("rstp_mode",   int'(chs_mode[0]), 0);
    arst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
